// File: rtl/clk_gen_param.sv
// -----------------------------------------------------------------------------
// clk_gen_param
//   Clock generator running entirely on clk16f. It produces a bank of gated
//   power-of-two divided clocks, one programmable-ratio divided clock, a sync
//   marker on the common falling edge of the power-of-two bank, and a lock flag.
//   Every output is taken straight from a flop.
//
// Parameters
//   DIV0_LOG2  log2 of the channel 0 divide ratio (channel i divides by
//              2^(DIV0_LOG2+i)); must be >= 1
//   N_OUT      number of power-of-two channels
//   RATIO_W    width of the programmable ratio; must be >= 2
//
// Ports
//   clk16f      in   sole clock, rising edge
//   reset_L     in   synchronous active-low reset
//   en          in   per-channel enable request, applied at period boundaries
//   ratio       in   requested divide ratio for clk_prog
//   ratio_ld    in   one-cycle strobe capturing ratio
//   clk_div     out  gated power-of-two divided clocks
//   clk_prog    out  programmable-ratio divided clock
//   ratio_err   out  sticky: last loaded ratio was rejected (0 or 1)
//   sync_pulse  out  one cycle wide, marks the common falling edge of clk_div
//   locked      out  set once the slowest channel completes one period
// -----------------------------------------------------------------------------
module clk_gen_param #(
    parameter int DIV0_LOG2 = 2,
    parameter int N_OUT     = 3,
    parameter int RATIO_W   = 8
) (
    input  logic               clk16f,
    input  logic               reset_L,
    input  logic [N_OUT-1:0]   en,
    input  logic [RATIO_W-1:0] ratio,
    input  logic               ratio_ld,
    output logic [N_OUT-1:0]   clk_div,
    output logic               clk_prog,
    output logic               ratio_err,
    output logic               sync_pulse,
    output logic               locked
);

    // The shared counter spans the slowest channel, so it wraps freely.
    localparam int CW = DIV0_LOG2 + N_OUT - 1;

    localparam logic [CW-1:0]      CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [RATIO_W-1:0] P_ONE   = {{(RATIO_W-1){1'b0}}, 1'b1};
    localparam logic [RATIO_W-1:0] R_MIN   = {{(RATIO_W-2){1'b0}}, 2'b10};

    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_next;
    logic [N_OUT-1:0]   en_q;
    logic [N_OUT-1:0]   en_q_next;
    logic [N_OUT-1:0]   raw_next;
    logic [N_OUT-1:0]   at_bound;
    logic [N_OUT-1:0]   clk_div_next;

    logic [RATIO_W-1:0] pcnt;
    logic [RATIO_W-1:0] pcnt_inc;
    logic [RATIO_W-1:0] pcnt_next;
    logic [RATIO_W-1:0] r_act;
    logic [RATIO_W-1:0] r_act_next;
    logic [RATIO_W-1:0] pend;
    logic [RATIO_W-1:0] pend_next;
    logic [RATIO_W-1:0] half_next;
    logic               pend_vld;
    logic               pend_vld_next;
    logic               wrap;
    logic               clk_prog_next;
    logic               ratio_err_next;
    logic               sync_next;
    logic               locked_next;

    assign cnt_next = cnt + CNT_ONE;

    // Channel i is high in the upper half of its period: that is simply the
    // top bit of the counter modulo D_i. The enable is re-sampled only while
    // the counter sits at the start of the channel's period, i.e. inside the
    // low phase, so a change can never clip or create a high phase.
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_ch
        localparam int LG = DIV0_LOG2 + gi;
        assign raw_next[gi] = cnt_next[LG-1];
        assign at_bound[gi] = (cnt[LG-1:0] == '0);
    end

    always_comb begin
        en_q_next = en_q;
        for (int i = 0; i < N_OUT; i++) begin
            if (at_bound[i]) begin
                en_q_next[i] = en[i];
            end
        end
        clk_div_next = raw_next & en_q_next;
        sync_next    = (cnt_next == '0);
        locked_next  = locked | sync_next;

        pcnt_inc  = pcnt + P_ONE;
        wrap      = (pcnt_inc == r_act);
        pcnt_next = wrap ? '0 : pcnt_inc;

        r_act_next     = r_act;
        pend_next      = pend;
        pend_vld_next  = pend_vld;
        ratio_err_next = ratio_err;

        // The wrap consumes whatever was pending before this edge; a load on
        // the same edge is queued behind it for the following wrap.
        if (wrap && pend_vld) begin
            r_act_next     = pend;
            pend_vld_next  = 1'b0;
            ratio_err_next = 1'b0;
        end

        if (ratio_ld) begin
            if (ratio < R_MIN) begin
                pend_vld_next  = 1'b0;
                ratio_err_next = 1'b1;
            end else begin
                pend_next     = ratio;
                pend_vld_next = 1'b1;
            end
        end

        // Low for ceil(R/2) counts, high for floor(R/2).
        half_next     = (r_act_next >> 1) + {{(RATIO_W-1){1'b0}}, r_act_next[0]};
        clk_prog_next = (pcnt_next >= half_next);
    end

    always_ff @(posedge clk16f) begin
        if (!reset_L) begin
            cnt        <= '0;
            en_q       <= '0;
            clk_div    <= '0;
            sync_pulse <= 1'b0;
            locked     <= 1'b0;
            pcnt       <= '0;
            r_act      <= R_MIN;
            pend       <= '0;
            pend_vld   <= 1'b0;
            clk_prog   <= 1'b0;
            ratio_err  <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            en_q       <= en_q_next;
            clk_div    <= clk_div_next;
            sync_pulse <= sync_next;
            locked     <= locked_next;
            pcnt       <= pcnt_next;
            r_act      <= r_act_next;
            pend       <= pend_next;
            pend_vld   <= pend_vld_next;
            clk_prog   <= clk_prog_next;
            ratio_err  <= ratio_err_next;
        end
    end

endmodule

// File: tb/tb_clk_gen_param.sv
// -----------------------------------------------------------------------------
// tb_clk_gen_param
//   Drives a default instance (/4,/8,/16) and an N_OUT=4, DIV0_LOG2=1 instance
//   (/2,/4,/8,/16) from the same clock, reset and ratio controls.
//   t is the edge count since the most recent reset release.
// -----------------------------------------------------------------------------
module tb_clk_gen_param;

    logic clk16f = 1'b0;
    always #5 clk16f = ~clk16f;

    logic       reset_L;
    logic [2:0] en_a;
    logic [3:0] en_b;
    logic [7:0] ratio;
    logic       ratio_ld;

    logic [2:0] div_a;
    logic       prog_a, err_a, sync_a, lock_a;
    logic [3:0] div_b;
    logic       prog_b, err_b, sync_b, lock_b;

    int n_chk  = 0;
    int n_fail = 0;
    int t      = 0;

    clk_gen_param dut_a (
        .clk16f     (clk16f),
        .reset_L    (reset_L),
        .en         (en_a),
        .ratio      (ratio),
        .ratio_ld   (ratio_ld),
        .clk_div    (div_a),
        .clk_prog   (prog_a),
        .ratio_err  (err_a),
        .sync_pulse (sync_a),
        .locked     (lock_a)
    );

    clk_gen_param #(.DIV0_LOG2(1), .N_OUT(4), .RATIO_W(8)) dut_b (
        .clk16f     (clk16f),
        .reset_L    (reset_L),
        .en         (en_b),
        .ratio      (ratio),
        .ratio_ld   (ratio_ld),
        .clk_div    (div_b),
        .clk_prog   (prog_b),
        .ratio_err  (err_b),
        .sync_pulse (sync_b),
        .locked     (lock_b)
    );

    typedef struct {
        logic [2:0] en;
        logic       ld;
        logic [7:0] ratio;
        logic [2:0] div;
        logic       prog;
        logic       err;
        logic       sync;
        logic       lock;
    } vec_t;

    vec_t vecs [32];

    task automatic tick();
        @(posedge clk16f);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0d: got %0h, expected %0h", name, t, act, exp);
        end
    endtask

    function automatic logic [2:0] exp_div_a(input int tt);
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = ((tt % (4 << i)) >= (2 << i));
        return r;
    endfunction

    function automatic logic [3:0] exp_div_b(input int tt);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = ((tt % (2 << i)) >= (1 << i));
        return r;
    endfunction

    // clk_prog after the ratio sequence that starts with R=4 active from t=24
    function automatic logic exp_prog_p3(input int tt);
        if (tt <= 40)      return (tt % 4) >= 2;
        else if (tt <= 44) return ((tt - 40) % 4) >= 2;
        else if (tt <= 48) return ((tt - 44) % 2) == 1;
        else if (tt <= 53) return ((tt - 48) % 5) >= 3;
        else               return ((tt - 53) % 3) >= 2;
    endfunction

    task automatic check_all(input logic [2:0] e_div, input logic e_prog,
                             input logic e_err, input logic e_sync, input logic e_lock);
        chk("a_clk_div",    div_a,  e_div);
        chk("a_clk_prog",   prog_a, e_prog);
        chk("a_ratio_err",  err_a,  e_err);
        chk("a_sync_pulse", sync_a, e_sync);
        chk("a_locked",     lock_a, e_lock);
        chk("b_clk_div",    div_b,  exp_div_b(t));
        chk("b_clk_prog",   prog_b, e_prog);
        chk("b_ratio_err",  err_b,  e_err);
        chk("b_sync_pulse", sync_b, e_sync);
        chk("b_locked",     lock_b, e_lock);
    endtask

    task automatic check_zero();
        chk("rst_a_clk_div",    div_a,  0);
        chk("rst_a_clk_prog",   prog_a, 0);
        chk("rst_a_ratio_err",  err_a,  0);
        chk("rst_a_sync_pulse", sync_a, 0);
        chk("rst_a_locked",     lock_a, 0);
        chk("rst_b_clk_div",    div_b,  0);
        chk("rst_b_clk_prog",   prog_b, 0);
        chk("rst_b_ratio_err",  err_b,  0);
        chk("rst_b_sync_pulse", sync_b, 0);
        chk("rst_b_locked",     lock_b, 0);
    endtask

    initial begin
        logic [2:0] e_div;
        logic       e_prog;

        //            en      ld    ratio  div     prog  err   sync  lock
        vecs[0]  = '{3'b111, 1'b0, 8'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'b111, 1'b0, 8'd0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'b111, 1'b0, 8'd0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'b111, 1'b0, 8'd0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'b111, 1'b0, 8'd0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'b111, 1'b0, 8'd0, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'b111, 1'b0, 8'd0, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b111, 1'b0, 8'd0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'b111, 1'b0, 8'd0, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'b111, 1'b0, 8'd0, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3'b111, 1'b0, 8'd0, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{3'b111, 1'b0, 8'd0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{3'b111, 1'b0, 8'd0, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{3'b111, 1'b0, 8'd0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{3'b111, 1'b0, 8'd0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{3'b111, 1'b0, 8'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{3'b111, 1'b0, 8'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{3'b111, 1'b1, 8'd1, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[18] = '{3'b111, 1'b0, 8'd0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[19] = '{3'b111, 1'b0, 8'd0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[20] = '{3'b111, 1'b0, 8'd0, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[21] = '{3'b111, 1'b0, 8'd0, 3'b011, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[22] = '{3'b111, 1'b1, 8'd4, 3'b011, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[23] = '{3'b111, 1'b0, 8'd0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[24] = '{3'b111, 1'b0, 8'd0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[25] = '{3'b111, 1'b0, 8'd0, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[26] = '{3'b111, 1'b0, 8'd0, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[27] = '{3'b111, 1'b0, 8'd0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[28] = '{3'b111, 1'b0, 8'd0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[29] = '{3'b111, 1'b0, 8'd0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[30] = '{3'b111, 1'b0, 8'd0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[31] = '{3'b111, 1'b0, 8'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1};

        // Held in reset with enables up: everything must stay low.
        reset_L  = 1'b0;
        en_a     = 3'b111;
        en_b     = 4'hF;
        ratio    = 8'd0;
        ratio_ld = 1'b0;
        repeat (3) tick();
        check_zero();

        // Free run with ratio=3 loaded at t=1 and en[1] dropped over t=10..19.
        reset_L = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            en_a = 3'b111;
            if (k >= 10 && k < 20) en_a[1] = 1'b0;
            ratio_ld = (k == 1);
            ratio    = 8'd3;
            tick();
            t = k;
            e_div = exp_div_a(k);
            if (k >= 16 && k < 28) e_div[1] = 1'b0;
            e_prog = (k == 1) || (k >= 2 && ((k - 2) % 3) == 2);
            check_all(e_div, e_prog, 1'b0, (k % 16) == 0, k >= 16);
        end

        // One-cycle reset in mid-operation.
        en_a     = 3'b111;
        ratio_ld = 1'b0;
        reset_L  = 1'b0;
        tick();
        t = 37;
        check_zero();
        reset_L = 1'b1;

        // Restart from t=1: base pattern, then reject ratio=1, then load 4.
        for (int k = 0; k < 32; k++) begin
            en_a     = vecs[k].en;
            ratio_ld = vecs[k].ld;
            ratio    = vecs[k].ratio;
            tick();
            t = k + 1;
            check_all(vecs[k].div, vecs[k].prog, vecs[k].err, vecs[k].sync, vecs[k].lock);
        end

        // Load on a wrap edge (t=40), then last-one-wins (9 then 3).
        for (int k = 33; k <= 59; k++) begin
            ratio_ld = (k == 40) || (k == 47) || (k == 49) || (k == 50);
            ratio    = (k == 40) ? 8'd2 : (k == 47) ? 8'd5 : (k == 49) ? 8'd9 : 8'd3;
            tick();
            t = k;
            check_all(exp_div_a(k), exp_prog_p3(k), 1'b0, (k % 16) == 0, 1'b1);
        end
        ratio_ld = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_gen_param.md
CLK_GEN_PARAM -- requirements
Module: clk_gen_param

Interface
REQ-001 Parameter DIV0_LOG2, default 2: log2 of the divide ratio of channel 0 (default /4).
REQ-002 Parameter N_OUT, default 3: number of power-of-two channels; channel i divides by D_i = 2^(DIV0_LOG2+i), so defaults give /4, /8, /16.
REQ-003 Parameter RATIO_W, default 8: width of the programmable-ratio input.
REQ-004 clk16f  input  1  sole clock; all flops on its rising edge.
REQ-005 reset_L  input  1  reset, synchronous and active-low.
REQ-006 en  input  N_OUT  per-channel enable request for clk_div.
REQ-007 ratio  input  RATIO_W  requested divide ratio for clk_prog.
REQ-008 ratio_ld  input  1  one-cycle strobe that captures ratio.
REQ-009 clk_div  output  N_OUT  gated power-of-two divided clocks.
REQ-010 clk_prog  output  1  programmable-ratio divided clock.
REQ-011 ratio_err  output  1  sticky flag: last loaded ratio rejected.
REQ-012 sync_pulse  output  1  one-cycle marker of the common falling edge of all power-of-two channels.
REQ-013 locked  output  1  high once all channels have completed one full period.

Function
REQ-014 Every output SHALL be driven directly by a flop; no combinational gating on any output path.
REQ-015 Edge t is the t-th clk16f rising edge with reset_L sampled high; t=1 is the first edge after reset release.
REQ-016 Raw channel i after edge t SHALL be 1 iff (t mod D_i) >= D_i/2 (low D_i/2 cycles, then high D_i/2 cycles; 50% duty).
REQ-017 Enable register en_q[i] SHALL sample en[i] only at edges where t mod D_i == 0; clk_div[i] = raw_i AND en_q[i], evaluated in the next-state logic.
REQ-018 Toggling en mid-period SHALL NOT produce a runt pulse or truncated high phase; the change takes effect at the next period boundary of that channel.
REQ-019 Programmable counter pcnt SHALL count 0..R_act-1 and wrap to 0; clk_prog after each edge = 1 iff the new pcnt >= ceil(R_act/2) (low ceil(R/2) cycles, high floor(R/2) cycles).
REQ-020 ratio_ld high at an edge SHALL capture ratio into a pending register; if several loads occur before a wrap, the last one wins.
REQ-021 A pending ratio >= 2 SHALL become R_act on the edge where pcnt wraps to 0, and SHALL clear ratio_err on that edge.
REQ-022 A load arriving on the wrap edge itself SHALL apply at the following wrap, not the current one.
REQ-023 A loaded ratio of 0 or 1 SHALL be rejected: R_act unchanged, pending discarded, ratio_err set on the edge after the strobe.
REQ-024 sync_pulse SHALL be 1 for exactly one cycle after each edge where t mod D_(N_OUT-1) == 0, regardless of en.
REQ-025 locked SHALL go 1 after edge t = D_(N_OUT-1) and remain 1 until reset.
REQ-026 Counter widths SHALL be sized from the parameters; the power-of-two counter wraps modulo D_(N_OUT-1) with no terminal-count stall.

Reset
REQ-027 On any edge with reset_L = 0, the block SHALL clear the counters, pcnt, en_q, clk_div, clk_prog, sync_pulse, locked, ratio_err and the pending register.
REQ-028 Reset SHALL set R_act = 2.
REQ-029 Reset asserted mid-operation SHALL take effect on the next edge, with no partial pulse completed.
REQ-030 While reset_L = 0, all outputs SHALL hold 0.

Verification
REQ-031 Defaults, en=3'b111, reset released: clk_div[0] high at t=2,3 and low at t=4,5; clk_div[2] rises at t=8; sync_pulse and locked at t=16; pattern repeats every 16 cycles.
REQ-032 en[1] deasserted at t=10: clk_div[1] completes its high phase through t=15 and stays 0 from t=16; reasserting en[1] at t=20 gives its first rise at t=28.
REQ-033 ratio=3 loaded at t=1 (R_act=2): switches at the first wrap (t=2); thereafter clk_prog is high 1 cycle, low 2 cycles, period 3.
REQ-034 ratio=1 loaded: ratio_err=1 on the next edge and clk_prog period unchanged; a following load of 4 clears ratio_err at its wrap and gives a 2-high/2-low clk_prog.
REQ-035 reset_L pulled low for 1 cycle at t=37: all outputs read 0 after that edge, locked drops to 0, and the REQ-031 sequence restarts from t=1.
REQ-036 Re-run REQ-031 with N_OUT=4, DIV0_LOG2=1: channels divide by /2, /4, /8, /16, and locked rises at t=16.
